// File: rtl/board_ram_ctrl.sv
// One player's tile board: a 256x2 cell store with a registered painter read port and a
// WRITE/FIRE/CLEAR/READ command port. Build with BOARD_PLACE_PROTECT_EN to reject WRITEs to non-EMPTY cells.
module board_ram_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_col,
    input  logic [3:0] cmd_row,
    input  logic [1:0] cmd_data,
    output logic       rsp_valid,
    output logic [1:0] rsp_data,
    output logic       rsp_err,
    output logic [6:0] ships_left,
    input  logic [9:0] disp_addr,
    output logic [1:0] disp_data,
    output logic [1:0] dbg_state
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HIT   = 2'd1;
    localparam logic [1:0] MISS  = 2'd2;
    localparam logic [1:0] SHIP  = 2'd3;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_FIRE  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    localparam logic [4:0] COLS5 = 5'(COLS);
    localparam logic [4:0] ROWS5 = 5'(ROWS);
    localparam logic [6:0] SHIP_MAX = 7'd100;

`ifdef BOARD_PLACE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {SWEEP = 2'd0, IDLE = 2'd1, FETCH = 2'd2, APPLY = 2'd3} state_t;

    state_t     state, state_nxt;
    logic [1:0] mem [0:255];
    logic [7:0] sweep_idx;
    logic       from_clear;
    logic [1:0] op_q, data_q;
    logic [3:0] col_q, row_q;
    logic       in_range_q;

    logic [1:0] cur, cmd_wval, res_data;
    logic       cmd_wr, res_err, ship_inc, ship_dec;
    logic       wr_en;
    logic [7:0] wr_idx;
    logic [1:0] wr_val;
    logic       disp_in_range;

    // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready; the response is a
    // single-cycle rsp_valid pulse with no back-pressure.
    assign cmd_ready = (state == IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= SWEEP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SWEEP: if (sweep_idx == 8'hFF) state_nxt = IDLE;
            IDLE:  if (cmd_valid) state_nxt = (cmd_op == OP_CLEAR) ? SWEEP : FETCH;
            FETCH: state_nxt = APPLY;
            APPLY: state_nxt = IDLE;
            default: state_nxt = SWEEP;
        endcase
    end

    // Resolve the captured command against the current cell while in FETCH.
    always_comb begin
        cur      = mem[{col_q, row_q}];
        cmd_wr   = 1'b0;
        cmd_wval = cur;
        res_data = cur;
        res_err  = 1'b0;
        ship_inc = 1'b0;
        ship_dec = 1'b0;
        if (!in_range_q) begin
            res_data = EMPTY;
            res_err  = 1'b1;
        end else begin
            case (op_q)
                OP_WRITE: begin
                    if (PROTECT && cur != EMPTY) begin
                        res_err = 1'b1;
                    end else begin
                        cmd_wr   = 1'b1;
                        cmd_wval = data_q;
                        res_data = data_q;
                        ship_inc = (cur != SHIP) && (data_q == SHIP);
                        ship_dec = (cur == SHIP) && (data_q != SHIP);
                    end
                end
                OP_FIRE: begin
                    if (cur == EMPTY) begin
                        cmd_wr   = 1'b1;
                        cmd_wval = MISS;
                        res_data = MISS;
                    end else if (cur == SHIP) begin
                        cmd_wr   = 1'b1;
                        cmd_wval = HIT;
                        res_data = HIT;
                        ship_dec = 1'b1;
                    end else begin
                        res_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en  = (state == SWEEP) || ((state == FETCH) && cmd_wr);
        wr_idx = (state == SWEEP) ? sweep_idx : {col_q, row_q};
        wr_val = (state == SWEEP) ? EMPTY : cmd_wval;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_val;
    end

    assign disp_in_range = (disp_addr[9:5] < COLS5) && (disp_addr[4:0] < ROWS5);

    // Nonblocking read sees the pre-write cell, giving read-first behaviour on a same-cell collision.
    always_ff @(posedge clk) begin
        if (rst)                disp_data <= EMPTY;
        else if (disp_in_range) disp_data <= mem[{disp_addr[8:5], disp_addr[3:0]}];
        else                    disp_data <= EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx  <= 8'd0;
            from_clear <= 1'b0;
            op_q       <= 2'd0;
            data_q     <= 2'd0;
            col_q      <= 4'd0;
            row_q      <= 4'd0;
            in_range_q <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= EMPTY;
            rsp_err    <= 1'b0;
            ships_left <= 7'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                SWEEP: begin
                    sweep_idx <= sweep_idx + 8'd1;
                    if (sweep_idx == 8'hFF) begin
                        from_clear <= 1'b0;
                        if (from_clear) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= EMPTY;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        data_q     <= cmd_data;
                        col_q      <= cmd_col;
                        row_q      <= cmd_row;
                        in_range_q <= ({1'b0, cmd_col} < COLS5) && ({1'b0, cmd_row} < ROWS5);
                        if (cmd_op == OP_CLEAR) begin
                            from_clear <= 1'b1;
                            sweep_idx  <= 8'd0;
                            ships_left <= 7'd0;
                        end
                    end
                end
                FETCH: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= res_data;
                    rsp_err   <= res_err;
                    if (ship_inc && ships_left < SHIP_MAX)
                        ships_left <= ships_left + 7'd1;
                    else if (ship_dec && ships_left != 7'd0)
                        ships_left <= ships_left - 7'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_board_ram_ctrl.sv
// Bench for board_ram_ctrl: directed scenarios plus randomized commands checked against a
// board-array model that recounts SHIP cells from scratch.
module tb_board_ram_ctrl;
    localparam int COLS = 10;
    localparam int ROWS = 10;
`ifdef BOARD_PLACE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_col = 4'd0;
    logic [3:0] cmd_row = 4'd0;
    logic [1:0] cmd_data = 2'd0;
    logic       rsp_valid;
    logic [1:0] rsp_data;
    logic       rsp_err;
    logic [6:0] ships_left;
    logic [9:0] disp_addr = 10'd0;
    logic [1:0] disp_data;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int board [16][16];

    board_ram_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ships_left(ships_left), .disp_addr(disp_addr), .disp_data(disp_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void clear_model();
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 16; r++) board[c][r] = 0;
    endfunction

    function automatic int count_ships();
        int n = 0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) if (board[c][r] == 3) n++;
        return (n > 100) ? 100 : n;
    endfunction

    function automatic int model_cell(input int c, input int r);
        return (c < COLS && r < ROWS) ? board[c][r] : 0;
    endfunction

    task automatic model_cmd(input int op, input int col, input int row, input int d,
                             output int ed, output int ee);
        int cur;
        ed = 0;
        ee = 0;
        if (col >= COLS || row >= ROWS) begin
            ee = 1;
            return;
        end
        cur = board[col][row];
        if (op == 0) begin
            if (PROTECT && cur != 0) begin ed = cur; ee = 1; end
            else begin board[col][row] = d; ed = d; end
        end else if (op == 1) begin
            if (cur == 0)      begin board[col][row] = 2; ed = 2; end
            else if (cur == 3) begin board[col][row] = 1; ed = 1; end
            else               begin ed = cur; ee = 1; end
        end else begin
            ed = cur;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_cmd(input int op, input int col, input int row, input int d,
                          output logic [1:0] rd, output logic re);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_col   = 4'(col);
        cmd_row   = 4'(row);
        cmd_data  = 2'(d);
        while (!cmd_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
            cmd_valid = 1'b0;
            rd = 2'd0; re = 1'b1;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_quiet: rsp_valid=%0b cmd_ready=%0b required 0 0", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_latency: rsp_valid=%0b at T+2 required 1", rsp_valid);
        end
        rd = rsp_data;
        re = rsp_err;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== rd || rsp_err !== re) begin
            n_fail++;
            $display("FAIL rsp_pulse_hold: rsp_valid=%0b cmd_ready=%0b data=%0d err=%0b required 0 1 %0d %0b",
                     rsp_valid, cmd_ready, rsp_data, rsp_err, rd, re);
        end
    endtask

    task automatic run_cmd(input int op, input int col, input int row, input int d, input string name);
        int ed, ee;
        logic [1:0] rd;
        logic re;
        model_cmd(op, col, row, d, ed, ee);
        do_cmd(op, col, row, d, rd, re);
        n_tests++;
        if (rd !== 2'(ed) || re !== 1'(ee)) begin
            n_fail++;
            $display("FAIL %s rsp: op=%0d (%0d,%0d) data=%0d err=%0b required data=%0d err=%0d",
                     name, op, col, row, rd, re, ed, ee);
        end
        n_tests++;
        if (ships_left !== 7'(count_ships())) begin
            n_fail++;
            $display("FAIL %s ships_left: got %0d required %0d", name, ships_left, count_ships());
        end
    endtask

    task automatic check_disp(input int c, input int r, input string name);
        @(negedge clk);
        disp_addr = {5'(c), 5'(r)};
        @(negedge clk);
        n_tests++;
        if (disp_data !== 2'(model_cell(c, r))) begin
            n_fail++;
            $display("FAIL %s disp(%0d,%0d): got %0d required %0d", name, c, r, disp_data, model_cell(c, r));
        end
    endtask

    // Called on the first negedge of a sweep; counts not-ready cycles and response pulses.
    task automatic wait_sweep(input string name, input bit expect_rsp);
        int lo = 0;
        int early_rsp = 0;
        int bad_ships = 0;
        while (!cmd_ready && lo < 400) begin
            if (rsp_valid) early_rsp++;
            if (ships_left != 7'd0) bad_ships++;
            lo++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (lo != 256) begin
            n_fail++;
            $display("FAIL %s sweep_len: cmd_ready low %0d cycles required 256", name, lo);
        end
        n_tests++;
        if (early_rsp != 0 || bad_ships != 0) begin
            n_fail++;
            $display("FAIL %s sweep_quiet: rsp pulses %0d nonzero ships %0d required 0 0", name, early_rsp, bad_ships);
        end
        n_tests++;
        if (rsp_valid !== expect_rsp || (expect_rsp && (rsp_data !== 2'd0 || rsp_err !== 1'b0))) begin
            n_fail++;
            $display("FAIL %s sweep_rsp: valid=%0b data=%0d err=%0b required valid=%0b data=0 err=0",
                     name, rsp_valid, rsp_data, rsp_err, expect_rsp);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s sweep_rsp_once: rsp_valid=%0b required 0", name, rsp_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'd3;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, ships_left, disp_data} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b rv=%0b rd=%0d re=%0b ships=%0d disp=%0d required all 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_err, ships_left, disp_data);
        end
        rst = 1'b0;
        clear_model();
        wait_sweep("reset", 1'b0);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) check_disp(c, r, "reset_empty");
    endtask

    task automatic test_write_ship();
        run_cmd(0, 3, 4, 3, "write_ship");
        check_disp(3, 4, "write_ship");
    endtask

    task automatic test_fire();
        run_cmd(1, 3, 4, 0, "fire_hit");
        run_cmd(1, 3, 4, 0, "fire_repeat");
        run_cmd(1, 0, 0, 0, "fire_miss");
        check_disp(0, 0, "fire_miss");
    endtask

    task automatic test_out_of_range();
        run_cmd(0, 10, 2, 3, "oor_write");
        run_cmd(1, 2, 10, 0, "oor_fire");
        run_cmd(3, 15, 15, 0, "oor_read");
        check_disp(10, 2, "oor");
        check_disp(31, 31, "oor");
        check_disp(3, 15, "oor");
    endtask

    task automatic test_back_to_back();
        int acc_q[$];
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'd3;
        cmd_col = 4'd1;
        cmd_row = 4'd1;
        for (int i = 0; i < 13; i++) begin
            if (cmd_ready) acc_q.push_back(i);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (acc_q.size() < 4) begin
            n_fail++;
            $display("FAIL b2b_count: %0d accepts required >= 4", acc_q.size());
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_tests++;
            if (acc_q[i] - acc_q[i-1] != 3) begin
                n_fail++;
                $display("FAIL b2b_gap: gap %0d required 3", acc_q[i] - acc_q[i-1]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            int sel = $urandom_range(0, 9);
            int op = (sel < 4) ? 0 : (sel < 8) ? 1 : 3;
            run_cmd(op, $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3), "random");
            if ($urandom_range(0, 3) == 0)
                check_disp($urandom_range(0, 12), $urandom_range(0, 12), "random");
        end
    endtask

    task automatic test_clear();
        int w = 0;
        for (int i = 0; i < 5; i++) begin
            if (PROTECT) run_cmd(0, i * 2, 9 - i, 0, "clear_prep");
            run_cmd(0, i * 2, 9 - i, 3, "clear_place");
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        cmd_col = 4'd7;
        cmd_row = 4'd7;
        while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        clear_model();
        wait_sweep("clear", 1'b1);
        n_tests++;
        if (ships_left !== 7'd0) begin
            n_fail++;
            $display("FAIL clear_ships: got %0d required 0", ships_left);
        end
        check_disp(0, 9, "clear");
        check_disp(8, 5, "clear");
        check_disp(3, 4, "clear");
    endtask

    task automatic test_reset_mid_sweep();
        int w = 0;
        run_cmd(0, 5, 5, 3, "midrst_place");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        wait_sweep("midrst", 1'b0);
        n_tests++;
        if (ships_left !== 7'd0) begin
            n_fail++;
            $display("FAIL midrst_ships: got %0d required 0", ships_left);
        end
        check_disp(5, 5, "midrst");
        run_cmd(3, 5, 5, 0, "midrst_read");
    endtask

`ifdef BOARD_PLACE_PROTECT_EN
    task automatic test_protect();
        run_cmd(0, 2, 2, 3, "protect_place");
        run_cmd(0, 2, 2, 2, "protect_reject");
        check_disp(2, 2, "protect");
    endtask
`endif

    initial begin
        clear_model();
        test_reset();
        test_write_ship();
        test_fire();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_clear();
        test_reset_mid_sweep();
`ifdef BOARD_PLACE_PROTECT_EN
        test_protect();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
